// File: rtl/uarttx_buffer_if.sv
// Purpose: bundles the CPU-side write port and the transmitter go/busy handshake of uarttx_buffer.
// Latency: none, plain wires.
// Backpressure: none here; the buffer reports full/overflow and the transmitter holds busy.
// Ports: wr_data/wr_en (enqueue), full/count/overflow/idle (status),
//        uart_data/uart_go (to transmitter), uart_busy (from transmitter).
interface uarttx_buffer_if #(
    parameter int DepthLog2 = 4
);
    logic [7:0]         wr_data;
    logic               wr_en;
    logic               full;
    logic [DepthLog2:0] count;
    logic               overflow;
    logic               idle;
    logic [7:0]         uart_data;
    logic               uart_go;
    logic               uart_busy;

    // The buffer itself.
    modport slave (
        input  wr_data, wr_en, uart_busy,
        output full, count, overflow, idle, uart_data, uart_go
    );

    // The environment: bus writer plus transmitter.
    modport master (
        output wr_data, wr_en, uart_busy,
        input  full, count, overflow, idle, uart_data, uart_go
    );
endinterface

// File: rtl/uarttx_buffer.sv
// Purpose: byte FIFO feeding a UART transmitter through a four-phase go/busy handshake.
// Latency: a write into an empty idle buffer raises uart_go two clock edges later.
// Backpressure: writes while full are dropped and flagged by a one-cycle overflow pulse.
// Ports: clk, rst_n (async active-low), bus (uarttx_buffer_if.slave: write port,
//        status outputs, uart_data/uart_go to the transmitter, uart_busy back).
module uarttx_buffer #(
    parameter int DepthLog2 = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uarttx_buffer_if.slave  bus
);
    localparam int Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0]   DepthCnt = {1'b1, {DepthLog2{1'b0}}};
    localparam logic [DepthLog2:0]   CntOne   = (DepthLog2 + 1)'(1);
    localparam logic [DepthLog2-1:0] PtrOne   = DepthLog2'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DepthLog2:0]   count_q, count_d;
    logic [7:0]           mem_q [Depth];
    logic [7:0]           data_q;
    logic                 ovf_q;
    logic                 full;
    logic                 push;
    logic                 pop;

    // full is judged on the pre-edge count, so a pop in the same cycle
    // does not rescue a write that arrives while full.
    assign full = (count_q == DepthCnt);
    assign push = bus.wr_en && !full;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bus.uart_busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.uart_busy) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // go is low this cycle so the transmitter can return to idle
                // before the next byte is offered.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CntOne;
        else if (pop && !push) count_d = count_q - CntOne;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= bus.wr_en && full;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // go is a decode of the registered state, so it is glitch-free and
    // drops immediately with the asynchronous reset.
    assign bus.uart_go   = (state_q == S_START) || (state_q == S_WAIT);
    assign bus.uart_data = data_q;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.idle      = (state_q == S_IDLE) && (count_q == '0);
endmodule

// File: tb/tb_uarttx_buffer.sv
// Purpose: self-checking bench for uarttx_buffer with a behavioural transmitter and queue model.
// Latency: checks go rising two edges after a write into an empty buffer.
// Backpressure: exercises full/overflow with a four-entry buffer.
module tb_uarttx_buffer;
    localparam int DL2      = 2;
    localparam int DEPTH    = 1 << DL2;
    localparam int BIT_TIME = 4;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    uarttx_buffer_if #(.DepthLog2(DL2)) bus ();

    uarttx_buffer #(.DepthLog2(DL2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural transmitter ----------------
    logic       tx_busy;
    logic       tx_wait_low;
    logic       tx_line;
    logic [9:0] tx_sh;
    logic [7:0] tx_cap;
    int         tx_bt;
    int         tx_nb;
    logic [7:0] rx_q[$];
    bit         bits_q[$];

    assign bus.uart_busy = tx_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy     <= 1'b0;
            tx_wait_low <= 1'b0;
            tx_line     <= 1'b1;
        end else if (!tx_busy && !tx_wait_low && bus.uart_go) begin
            tx_cap = bus.uart_data;
            rx_q.push_back(tx_cap);
            tx_sh = {1'b1, tx_cap, 1'b0};
            tx_bt = 0;
            tx_nb = 0;
            tx_busy <= 1'b1;
            tx_line <= tx_sh[0];
            bits_q.push_back(tx_sh[0]);
        end else if (tx_busy) begin
            check("data_stable", bus.uart_data, tx_cap);
            if (tx_bt == BIT_TIME - 1) begin
                tx_bt = 0;
                if (tx_nb == 9) begin
                    tx_busy     <= 1'b0;
                    tx_wait_low <= 1'b1;
                    tx_line     <= 1'b1;
                end else begin
                    tx_nb = tx_nb + 1;
                    tx_line <= tx_sh[tx_nb];
                    bits_q.push_back(tx_sh[tx_nb]);
                end
            end else begin
                tx_bt = tx_bt + 1;
            end
        end else if (tx_wait_low && !bus.uart_go) begin
            tx_wait_low <= 1'b0;
        end
    end

    // ---------------- queue-level model and per-cycle compare ----------------
    logic [7:0] mq[$];
    bit         m_inflight, m_acc, m_gap, m_ov;
    logic [7:0] m_data;
    bit         full_pre, push_pre;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_inflight = 0;
            m_acc      = 0;
            m_gap      = 0;
            m_ov       = 0;
            m_data     = 8'h00;
        end else begin
            full_pre = (mq.size() == DEPTH);
            push_pre = bus.wr_en && !full_pre;
            m_ov     = bus.wr_en && full_pre;
            if (m_inflight) begin
                // byte offered: finished once busy has been seen high then low
                if (tx_busy) m_acc = 1;
                else if (m_acc) begin
                    m_inflight = 0;
                    m_gap      = 1;
                end
            end else if (mq.size() != 0) begin
                m_data     = mq.pop_front();
                m_inflight = 1;
                m_acc      = 0;
                m_gap      = 0;
            end else begin
                m_gap = 0;
            end
            if (push_pre) mq.push_back(bus.wr_data);
            #1;
            check("count",     bus.count,     mq.size());
            check("full",      bus.full,      mq.size() == DEPTH);
            check("overflow",  bus.overflow,  m_ov);
            check("uart_go",   bus.uart_go,   m_inflight);
            check("uart_data", bus.uart_data, m_data);
            check("idle",      bus.idle,      !m_inflight && !m_gap && mq.size() == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_drained();
        bit ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (bus.idle && !tx_busy && !tx_wait_low) ok = 1;
        end
        check("drain_timeout", ok, 1);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] exp[$]);
        check({nm, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            check({nm, "_byte"}, rx_q[i], exp[i]);
    endtask

    logic [7:0] exp_q[$];
    bit         frame_bits[10];
    bit         ok_w;

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_count", bus.count, 0);
        check("rst_idle", bus.idle, 1);
        check("rst_go", bus.uart_go, 0);
        check("rst_data", bus.uart_data, 8'h00);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte A5
        rx_q.delete();
        bits_q.delete();
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        @(posedge clk); #2;
        check("t1_count_after_e0", bus.count, 1);
        check("t1_go_after_e0", bus.uart_go, 0);
        @(negedge clk) bus.wr_en = 1'b0;
        @(posedge clk); #2;
        check("t1_go_after_e1", bus.uart_go, 1);
        check("t1_data_after_e1", bus.uart_data, 8'hA5);
        wait_drained();
        exp_q = {8'hA5};
        check_rx("t1_rx", exp_q);
        frame_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        check("t1_bits_len", bits_q.size(), 10);
        for (int i = 0; i < 10 && i < bits_q.size(); i++)
            check("t1_line_bit", bits_q[i], frame_bits[i]);
        check("t1_idle_end", bus.idle, 1);

        // burst 01..04
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
        end
        @(negedge clk) bus.wr_en = 1'b0;
        check("t2_count_after_burst", bus.count, 3);
        wait_drained();
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04};
        check_rx("t2_rx", exp_q);
        check("t2_count_end", bus.count, 0);

        // full / overflow: six writes, the sixth dropped
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
        end
        @(negedge clk) bus.wr_en = 1'b0;
        check("t3_ovf_pulse", bus.overflow, 1);
        check("t3_full", bus.full, 1);
        check("t3_count_full", bus.count, 4);
        @(posedge clk); #2;
        check("t3_ovf_one_cycle", bus.overflow, 0);
        wait_drained();
        exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_rx("t3_rx", exp_q);

        // wrap-around: ten spaced bytes
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
            exp_q.push_back(8'(8'h20 + i));
            @(negedge clk) bus.wr_en = 1'b0;
            repeat (40) @(negedge clk);
        end
        wait_drained();
        check_rx("t4_rx", exp_q);

        // push and pop on the release edge with count == 1
        rx_q.delete();
        @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h41;
        @(negedge clk); bus.wr_data = 8'h42;
        @(negedge clk); bus.wr_en = 1'b0;
        ok_w = 0;
        for (int c = 0; c < 200 && !ok_w; c++) begin
            @(negedge clk);
            if (bus.uart_go && !tx_busy && tx_wait_low) ok_w = 1;
        end
        check("t5_wait_timeout", ok_w, 1);
        @(negedge clk);
        check("t5_release_go", bus.uart_go, 0);
        check("t5_release_count", bus.count, 1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h43;
        @(posedge clk); #2;
        check("t5_count_held", bus.count, 1);
        check("t5_go_back", bus.uart_go, 1);
        check("t5_data_next", bus.uart_data, 8'h42);
        @(negedge clk) bus.wr_en = 1'b0;
        wait_drained();
        exp_q = {8'h41, 8'h42, 8'h43};
        check_rx("t5_rx", exp_q);

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h77 + i);
        end
        @(negedge clk) bus.wr_en = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_pre_busy", tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_go", bus.uart_go, 0);
        check("t6_rst_count", bus.count, 0);
        check("t6_rst_idle", bus.idle, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        @(negedge clk) bus.wr_en = 1'b0;
        wait_drained();
        exp_q = {8'h3C};
        check_rx("t6_rx", exp_q);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
